// File: rtl/bar_graph_controller_if.sv
// Height-write port of the bar-graph controller.
//   wr_valid  : writer has a new target height
//   wr_ready  : controller accepts a write this cycle
//   wr_index  : bar to update (IW bits)
//   wr_height : new target height in pixels
// master = sensor/UART side, slave = bar_graph_controller.
interface bar_graph_controller_if #(
  parameter int IW = 2
);
  logic          wr_valid;
  logic          wr_ready;
  logic [IW-1:0] wr_index;
  logic [7:0]    wr_height;

  modport master (output wr_valid, output wr_index, output wr_height, input wr_ready);
  modport slave  (input wr_valid, input wr_index, input wr_height, output wr_ready);
endinterface

// File: rtl/bar_graph_controller.sv
// Animated bar-graph controller for the VGA front end.
// Holds NUM_BARS target heights written over a valid/ready port. Once per frame
// (frame_tick) each displayed height is slewed toward its target by at most STEP
// pixels, so bar geometry only changes during vertical blank. The pixel under
// (x,y) is decoded into a registered on_bar/bar_id pair (1 clk latency).
// Ports:
//   clk, rst_n  : pixel clock, synchronous active-low reset
//   x, y        : current pixel coordinate
//   frame_tick  : one-cycle pulse at start of vertical blank
//   wr          : height-write port (slave modport)
//   on_bar      : registered, pixel lies inside a bar
//   bar_id      : registered, index of that bar (0 when on_bar=0)
//   busy        : registered, some displayed height differs from its target
module bar_graph_controller #(
  parameter int NUM_BARS   = 4,
  parameter int BAR_WIDTH  = 40,
  parameter int BAR_GAP    = 20,
  parameter int X_ORIGIN   = 100,
  parameter int Y_BASE     = 400,
  parameter int MAX_HEIGHT = 255,
  parameter int STEP       = 2,
  localparam int IW        = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic                   frame_tick,
  bar_graph_controller_if.slave  wr,
  output logic                   on_bar,
  output logic [IW-1:0]          bar_id,
  output logic                   busy
);

  localparam logic [7:0]  STEP_W = (STEP > 255) ? 8'd255 : 8'(STEP);
  localparam logic [7:0]  MAX_W  = (MAX_HEIGHT > 255) ? 8'd255 : 8'(MAX_HEIGHT);
  localparam logic [IW:0] NB_W   = NUM_BARS[IW:0];

  typedef enum logic {ST_IDLE = 1'b0, ST_UPDATE = 1'b1} state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic          rdy_nxt_s;
  logic          upd_en_s;
  logic          wr_ready_r;
  logic          wr_fire_s;
  logic          wr_in_range_s;
  logic [7:0]    wr_clip_s;
  logic [7:0]    tgt_r [NUM_BARS];
  logic [7:0]    cur_r [NUM_BARS];
  logic          hit_s;
  logic [IW-1:0] hit_id_s;
  logic          mism_s;
  logic          on_bar_r;
  logic [IW-1:0] bar_id_r;
  logic          busy_r;

  // Move c toward t by at most STEP, landing exactly on t without overshoot.
  function automatic logic [7:0] slew(input logic [7:0] c, input logic [7:0] t);
    logic [7:0] res;
    if (c < t) begin
      res = ((t - c) > STEP_W) ? (c + STEP_W) : t;
    end else if (c > t) begin
      res = ((c - t) > STEP_W) ? (c - STEP_W) : t;
    end else begin
      res = c;
    end
    return res;
  endfunction

  // Pixel inside bar idx of height h. 11-bit math keeps edges near 639/479 from
  // wrapping; the vertical test is written as y+h > Y_BASE to avoid underflow.
  function automatic logic in_bar(input int idx, input logic [9:0] px,
                                  input logic [9:0] py, input logic [7:0] h);
    logic [10:0] left;
    logic [10:0] right;
    logic [10:0] xs;
    logic [10:0] ys;
    left  = 11'(X_ORIGIN + idx * (BAR_WIDTH + BAR_GAP));
    right = left + 11'(BAR_WIDTH - 1);
    xs    = {1'b0, px};
    ys    = {1'b0, py};
    return (xs >= left) && (xs <= right) && (ys <= 11'(Y_BASE)) &&
           ((ys + {3'b000, h}) > 11'(Y_BASE));
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state: a tick in IDLE starts a one-cycle UPDATE; ticks in UPDATE are ignored
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (frame_tick) begin
          next_state_s = ST_UPDATE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_UPDATE: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: slew enable for the current state, ready for the next one
  always_comb begin
    upd_en_s  = 1'b0;
    rdy_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE:   upd_en_s = 1'b0;
      ST_UPDATE: upd_en_s = 1'b1;
      default:   upd_en_s = 1'b0;
    endcase
    case (next_state_s)
      ST_IDLE:   rdy_nxt_s = 1'b1;
      ST_UPDATE: rdy_nxt_s = 1'b0;
      default:   rdy_nxt_s = 1'b0;
    endcase
  end

  // Registered ready; held low through reset so nothing is accepted then
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ready_r <= 1'b0;
    end else begin
      wr_ready_r <= rdy_nxt_s;
    end
  end

  // Write handshake decode and height clipping
  always_comb begin
    wr_fire_s     = wr.wr_valid & wr_ready_r;
    wr_in_range_s = ({1'b0, wr.wr_index} < NB_W);
    if (wr.wr_height > MAX_W) begin
      wr_clip_s = MAX_W;
    end else begin
      wr_clip_s = wr.wr_height;
    end
  end

  // Targets follow accepted writes; displayed heights move only in UPDATE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BARS; i++) begin
        tgt_r[i] <= 8'd0;
        cur_r[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NUM_BARS; i++) begin
        if (upd_en_s) begin
          cur_r[i] <= slew(cur_r[i], tgt_r[i]);
        end else begin
          cur_r[i] <= cur_r[i];
        end
        if (wr_fire_s && wr_in_range_s && (wr.wr_index == IW'(i))) begin
          tgt_r[i] <= wr_clip_s;
        end else begin
          tgt_r[i] <= tgt_r[i];
        end
      end
    end
  end

  // Pixel hit test and mismatch detect; descending scan so the lowest index wins
  always_comb begin
    hit_s    = 1'b0;
    hit_id_s = '0;
    mism_s   = 1'b0;
    for (int i = NUM_BARS - 1; i >= 0; i--) begin
      if (in_bar(i, x, y, cur_r[i])) begin
        hit_s    = 1'b1;
        hit_id_s = IW'(i);
      end else begin
        hit_s    = hit_s;
        hit_id_s = hit_id_s;
      end
      if (cur_r[i] != tgt_r[i]) begin
        mism_s = 1'b1;
      end else begin
        mism_s = mism_s;
      end
    end
  end

  // Registered display and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      on_bar_r <= 1'b0;
      bar_id_r <= '0;
      busy_r   <= 1'b0;
    end else begin
      on_bar_r <= hit_s;
      bar_id_r <= hit_id_s;
      busy_r   <= mism_s;
    end
  end

  assign wr.wr_ready = wr_ready_r;
  assign on_bar      = on_bar_r;
  assign bar_id      = bar_id_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_bar_graph_controller.sv
module tb_bar_graph_controller;

  localparam int NB   = 5;
  localparam int BW   = 40;
  localparam int GAP  = 20;
  localparam int XO   = 100;
  localparam int YB   = 400;
  localparam int MAXH = 200;
  localparam int STP  = 2;

  logic       clk;
  logic       rst_n;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_tick;
  logic       on_bar;
  logic [2:0] bar_id;
  logic       busy;

  bar_graph_controller_if #(.IW(3)) bif ();

  bar_graph_controller #(
    .NUM_BARS(NB), .BAR_WIDTH(BW), .BAR_GAP(GAP), .X_ORIGIN(XO),
    .Y_BASE(YB), .MAX_HEIGHT(MAXH), .STEP(STP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .frame_tick(frame_tick),
    .wr(bif), .on_bar(on_bar), .bar_id(bar_id), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state (spec-level)
  int m_tgt [NB];
  int m_cur [NB];
  bit m_upd;
  bit m_ready;
  bit m_on;
  int m_id;
  bit m_busy;

  int n_checks;
  int n_fail;
  bit chk_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int left;
    bit hit;
    int hid;
    bit bz;
    bit was_upd;
    int d;
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin
        m_tgt[i] = 0;
        m_cur[i] = 0;
      end
      m_upd = 0; m_ready = 0; m_on = 0; m_id = 0; m_busy = 0;
    end else begin
      hit = 0; hid = 0; bz = 0;
      for (int i = 0; i < NB; i++) begin
        left = XO + i * (BW + GAP);
        if (!hit && int'(x) >= left && int'(x) < left + BW &&
            int'(y) <= YB && int'(y) > YB - m_cur[i]) begin
          hit = 1;
          hid = i;
        end
        if (m_cur[i] != m_tgt[i]) bz = 1;
      end
      was_upd = m_upd;
      if (was_upd) begin
        for (int i = 0; i < NB; i++) begin
          d = m_tgt[i] - m_cur[i];
          if (d > STP) d = STP;
          if (d < -STP) d = -STP;
          m_cur[i] = m_cur[i] + d;
        end
      end else if (bif.wr_valid && m_ready && int'(bif.wr_index) < NB) begin
        m_tgt[bif.wr_index] = (int'(bif.wr_height) > MAXH) ? MAXH : int'(bif.wr_height);
      end
      m_upd   = !was_upd && frame_tick;
      m_ready = !m_upd;
      m_on    = hit;
      m_id    = hid;
      m_busy  = bz;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("wr_ready", 32'(bif.wr_ready), 32'(m_ready));
      chk("on_bar",   32'(on_bar),       32'(m_on));
      chk("bar_id",   32'(bar_id),       32'(m_id));
      chk("busy",     32'(busy),         32'(m_busy));
    end
  end

  task automatic frame();
    frame_tick = 1'b1; step();
    frame_tick = 1'b0; step(); step(); step();
  endtask

  task automatic write(input int idx, input int h);
    bif.wr_valid = 1'b1; bif.wr_index = 3'(idx); bif.wr_height = 8'(h);
    step();
    bif.wr_valid = 1'b0;
  endtask

  task automatic probe(input string nm, input int px, input int py, input bit e_on, input int e_id);
    x = 10'(px); y = 10'(py);
    step();
    chk({nm, "_on"}, 32'(on_bar), 32'(e_on));
    chk({nm, "_id"}, 32'(bar_id), 32'(e_id));
  endtask

  initial begin
    n_checks = 0; n_fail = 0; chk_en = 0;
    rst_n = 1'b0; frame_tick = 1'b0; x = 10'd0; y = 10'd0;
    bif.wr_valid = 1'b1; bif.wr_index = 3'd1; bif.wr_height = 8'd50;

    // Reset held 3 clocks with a write pending
    step(); chk_en = 1; step(); step();
    chk("rst_ready", 32'(bif.wr_ready), 32'd0);
    chk("rst_on",    32'(on_bar),       32'd0);
    chk("rst_busy",  32'(busy),         32'd0);
    bif.wr_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rel_ready", 32'(bif.wr_ready), 32'd1);

    // Bar 1 ramps to 10 in 5 frames
    write(1, 10);
    for (int k = 1; k <= 5; k++) begin
      frame();
      chk("ramp1_cur", 32'(m_cur[1]), 32'(2 * k));
      if (k == 4) chk("busy_f4", 32'(busy), 32'd1);
    end
    chk("busy_f5", 32'(busy), 32'd0);
    probe("b1_base", 160, 400, 1'b1, 1);
    probe("b1_top",  160, 391, 1'b1, 1);
    probe("b1_above",160, 390, 1'b0, 0);
    probe("b1_right",199, 400, 1'b1, 1);
    probe("b1_gap",  200, 400, 1'b0, 0);
    probe("b1_left", 159, 400, 1'b0, 0);
    probe("below",   160, 401, 1'b0, 0);

    // Clip to MAX_HEIGHT, ramp up, then down to an odd value
    write(2, 255);
    chk("clip_tgt", 32'(m_tgt[2]), 32'd200);
    for (int k = 0; k < 120 && m_cur[2] != 200; k++) begin
      frame();
      probe("up_top", 220, YB + 1 - m_cur[2], m_cur[2] > 0, (m_cur[2] > 0) ? 2 : 0);
      probe("up_abv", 220, YB - m_cur[2], 1'b0, 0);
    end
    chk("up_done", 32'(m_cur[2]), 32'd200);
    probe("b2_201", 220, 201, 1'b1, 2);
    probe("b2_200", 259, 200, 1'b0, 0);
    write(2, 3);
    for (int k = 0; k < 120 && m_cur[2] != 3; k++) begin
      frame();
      probe("dn_top", 220, YB + 1 - m_cur[2], 1'b1, 2);
      probe("dn_abv", 220, YB - m_cur[2], 1'b0, 0);
    end
    chk("dn_done", 32'(m_cur[2]), 32'd3);
    probe("b2_398", 220, 398, 1'b1, 2);
    probe("b2_397", 220, 397, 1'b0, 0);

    // Out-of-range index accepted but dropped
    write(7, 77);
    chk("oor_ready", 32'(bif.wr_ready), 32'd1);
    write(5, 90);
    frame(); frame();
    chk("oor_busy", 32'(busy), 32'd0);

    // Write held across a frame_tick
    bif.wr_valid = 1'b1; bif.wr_index = 3'd0; bif.wr_height = 8'd1; frame_tick = 1'b1;
    step();
    chk("upd_ready", 32'(bif.wr_ready), 32'd0);
    frame_tick = 1'b0; bif.wr_height = 8'd40;
    step();
    chk("post_ready", 32'(bif.wr_ready), 32'd1);
    chk("held_cur0",  32'(m_cur[0]), 32'd1);
    step();
    bif.wr_valid = 1'b0;
    chk("held_tgt0", 32'(m_tgt[0]), 32'd40);
    probe("b0_399", 100, 399, 1'b0, 0);
    probe("b0_400", 100, 400, 1'b1, 0);

    // Reset pulse during an UPDATE
    write(3, 100);
    frame(); frame(); frame();
    probe("b3_pre", 280, 400, 1'b1, 3);
    frame_tick = 1'b1; step();
    frame_tick = 1'b0; rst_n = 1'b0; step();
    rst_n = 1'b1; step();
    chk("rst_cur3", 32'(m_cur[3]), 32'd0);
    probe("b3_post", 280, 400, 1'b0, 0);
    chk("rst_busy2", 32'(busy), 32'd0);
    frame();
    probe("b3_next", 280, 400, 1'b0, 0);
    probe("b1_gone", 160, 400, 1'b0, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n        = ($urandom_range(0, 299) != 0);
      frame_tick   = ($urandom_range(0, 7) == 0);
      bif.wr_valid = ($urandom_range(0, 1) == 1);
      bif.wr_index = 3'($urandom_range(0, 7));
      bif.wr_height = 8'($urandom);
      x = 10'($urandom_range(0, 639));
      if ($urandom_range(0, 1) == 1) y = 10'($urandom_range(300, 479));
      else y = 10'($urandom_range(0, 479));
      step();
    end
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
